// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-addressed data memory.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [31:0] BOOT_WORD = 32'h0136FF10;
    localparam int          CNT_W     = 8;

    // Wait cycles before an access completes: fixed base plus optional misalignment cost.
    function automatic logic [CNT_W-1:0] calc_wait(input logic [31:0] addr,
                                                   input int          base_wait,
                                                   input bit          misalign_pen,
                                                   input int          bytes);
        logic [31:0] rem;
        rem = misalign_pen ? (addr % 32'(bytes)) : 32'd0;
        return CNT_W'(base_wait) + CNT_W'(rem);
    endfunction

endpackage

// File: rtl/mem_dbg_port.sv
// One combinational little-endian word read from the flattened byte array.
// Bytes beyond the end of the array read as zero.
module mem_dbg_port #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 352,
    parameter int ADDR_W = 32
) (
    input  logic [8*DEPTH-1:0] mem_flat,
    input  logic [ADDR_W-1:0]  addr,
    output logic [DATA_W-1:0]  data
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    for (genvar k = 0; k < BYTES; k++) begin : g_b
        logic [ADDR_W:0] idx;
        // One extra bit keeps address+k from wrapping back into range.
        assign idx = {1'b0, addr} + (ADDR_W+1)'(k);
        assign data[8*k +: 8] = (idx < (ADDR_W+1)'(DEPTH)) ? mem_flat[8*idx[IDX_W-1:0] +: 8] : 8'h00;
    end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Byte-addressed little-endian memory with start/ready handshake and programmable latency.
// Define MEM_BOOT_INIT_EN to have reset preload word 0 with BOOT_WORD.
module byte_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter int DEPTH            = 352,
    parameter int ADDR_W           = 32,
    parameter int BASE_WAIT        = 0,
    parameter int MISALIGN_PENALTY = 1,
    parameter int NUM_DBG          = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       rwn,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W/8-1:0]        byte_en,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       ready,
    output logic                       done,
    output logic                       err,
    input  logic [NUM_DBG*ADDR_W-1:0]  dbg_addr,
    output logic [NUM_DBG*DATA_W-1:0]  dbg_data
);
    localparam int BYTES  = DATA_W / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       data_out_q, data_out_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    rwn_q, rwn_d;
    logic [BYTES-1:0]        be_q, be_d;
    logic [BYTES-1:0][7:0]   wdata_q, wdata_d;

    logic [8*DEPTH-1:0]      mem_flat;
    logic [DATA_W-1:0]       rd_data;
    logic                    in_range;
    logic                    wr_fire;

    assign in_range = ({1'b0, addr_q} + (ADDR_W+1)'(BYTES)) <= (ADDR_W+1)'(DEPTH);
    assign wr_fire  = (state_q == BUSY) && (cnt_q == '0) && !rwn_q && in_range;

    // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        data_out_d = data_out_q;
        addr_d     = addr_q;
        rwn_d      = rwn_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = address;
                    rwn_d   = rwn;
                    be_d    = byte_en;
                    wdata_d = data_in;
                    cnt_d   = calc_wait(32'(address), BASE_WAIT, MISALIGN_PENALTY != 0, BYTES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (!in_range) begin
                        err_d      = 1'b1;
                        data_out_d = '0;
                    end else if (rwn_q) begin
                        data_out_d = rd_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
            addr_q     <= '0;
            rwn_q      <= 1'b1;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
            addr_q     <= addr_d;
            rwn_q      <= rwn_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;
    assign done     = done_q;
    assign err      = err_q;

    // Each byte decodes its own write strobe from the captured request.
    for (genvar i = 0; i < DEPTH; i++) begin : g_byte
        logic [ADDR_W-1:0] off;
        logic              hit;
        logic [7:0]        byte_q;

        assign off = ADDR_W'(i) - addr_q;
        assign hit = wr_fire && (off < ADDR_W'(BYTES)) && be_q[off[BIDX_W-1:0]];

`ifdef MEM_BOOT_INIT_EN
        if (i < 4) begin : g_boot
            always_ff @(posedge clk or posedge reset) begin
                if (reset)    byte_q <= BOOT_WORD[8*i +: 8];
                else if (hit) byte_q <= wdata_q[off[BIDX_W-1:0]];
            end
        end else begin : g_plain
            always_ff @(posedge clk) begin
                if (hit) byte_q <= wdata_q[off[BIDX_W-1:0]];
            end
        end
`else
        // NOTE: array storage is deliberately left out of reset; contents survive a reset.
        always_ff @(posedge clk) begin
            if (hit) byte_q <= wdata_q[off[BIDX_W-1:0]];
        end
`endif

        assign mem_flat[8*i +: 8] = byte_q;
    end

    mem_dbg_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_port (
        .mem_flat (mem_flat),
        .addr     (addr_q),
        .data     (rd_data)
    );

    for (genvar p = 0; p < NUM_DBG; p++) begin : g_dbg
        mem_dbg_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dbg_port (
            .mem_flat (mem_flat),
            .addr     (dbg_addr[p*ADDR_W +: ADDR_W]),
            .data     (dbg_data[p*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl: one default instance and one with BASE_WAIT=2.
module tb_byte_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;

    logic        start, rwn;
    logic [31:0] address, data_in, data_out;
    logic [3:0]  byte_en;
    logic        ready, done, err;
    logic [95:0] dbg_addr, dbg_data;

    logic        start2, rwn2;
    logic [31:0] address2, data_in2, data_out2;
    logic [3:0]  byte_en2;
    logic        ready2, done2, err2;
    logic [31:0] dbg_addr2, dbg_data2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    byte_mem_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .rwn(rwn), .address(address),
        .byte_en(byte_en), .data_in(data_in), .data_out(data_out), .ready(ready),
        .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    byte_mem_ctrl #(.BASE_WAIT(2), .NUM_DBG(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .rwn(rwn2), .address(address2),
        .byte_en(byte_en2), .data_in(data_in2), .data_out(data_out2), .ready(ready2),
        .done(done2), .err(err2), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
    );

    // Issue one request while ready is high; return edges from accept to done (64 = timed out).
    task automatic req(input bit which, input logic [31:0] a, input bit r,
                       input logic [3:0] be, input logic [31:0] d, output int lat);
        if (!which) begin
            start = 1'b1; rwn = r; address = a; byte_en = be; data_in = d;
        end else begin
            start2 = 1'b1; rwn2 = r; address2 = a; byte_en2 = be; data_in2 = d;
        end
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(which ? done2 : done) && lat < 64);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0; rwn = 1'b1; address = '0; byte_en = '0; data_in = '0; dbg_addr = '0;
        start2 = 1'b0; rwn2 = 1'b1; address2 = '0; byte_en2 = '0; data_in2 = '0; dbg_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b1)        begin n_mis++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (done !== 1'b0)         begin n_mis++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0)          begin n_mis++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (data_out !== 32'h0)    begin n_mis++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        n_cmp++; if (ready2 !== 1'b1)       begin n_mis++; $display("FAIL reset_ready2: got %b want 1", ready2); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_boot;
        int lat;
`ifndef MEM_BOOT_INIT_EN
        req(1'b0, 32'd0, 1'b0, 4'hF, 32'h0136FF10, lat);
`endif
        dbg_addr[31:0] = 32'd0;
        req(1'b0, 32'd0, 1'b1, 4'h0, 32'h0, lat);
        n_cmp++; if (lat !== 1)                    begin n_mis++; $display("FAIL boot_latency: got %0d want 1", lat); end
        n_cmp++; if (data_out !== 32'h0136FF10)    begin n_mis++; $display("FAIL boot_read: got %h want 0136ff10", data_out); end
        n_cmp++; if (err !== 1'b0)                 begin n_mis++; $display("FAIL boot_err: got %b want 0", err); end
        n_cmp++; if (dbg_data[31:0] !== 32'h0136FF10) begin n_mis++; $display("FAIL boot_dbg0: got %h want 0136ff10", dbg_data[31:0]); end
    endtask

    task automatic test_byte_en;
        int lat;
        req(1'b0, 32'd4,   1'b0, 4'hF, 32'h0, lat);
        req(1'b0, 32'd8,   1'b0, 4'hF, 32'h0, lat);
        req(1'b0, 32'd348, 1'b0, 4'hF, 32'h44332211, lat);
        req(1'b0, 32'd8,   1'b0, 4'b0101, 32'hDEADBEEF, lat);
        n_cmp++; if (lat !== 1)    begin n_mis++; $display("FAIL be_write_latency: got %0d want 1", lat); end
        n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL be_write_err: got %b want 0", err); end
        dbg_addr[63:32] = 32'd8;
        req(1'b0, 32'd8, 1'b1, 4'h0, 32'h0, lat);
        n_cmp++; if (data_out !== 32'h00AD00EF)        begin n_mis++; $display("FAIL be_read: got %h want 00ad00ef", data_out); end
        n_cmp++; if (dbg_data[63:32] !== 32'h00AD00EF) begin n_mis++; $display("FAIL be_dbg1: got %h want 00ad00ef", dbg_data[63:32]); end
    endtask

    task automatic test_wait_states;
        int lat, ready_low, done_cnt;
        logic [31:0] rd;
        logic        rd_err;
        req(1'b1, 32'd0,  1'b0, 4'hF, 32'h33221100, lat);
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL wait_aligned_latency: got %0d want 3", lat); end
        req(1'b1, 32'd4,  1'b0, 4'hF, 32'h77665544, lat);
        req(1'b1, 32'd16, 1'b0, 4'hF, 32'h12345678, lat);
        ready_low = 0; done_cnt = 0; rd = '0; rd_err = 1'b1;
        start2 = 1'b1; rwn2 = 1'b1; address2 = 32'd3;
        @(posedge clk); #1;
        for (int c = 0; c < 12; c++) begin
            if (!ready2) ready_low++;
            if (done2) begin done_cnt++; rd = data_out2; rd_err = err2; end
            start2 = (c < 3);
            @(posedge clk); #1;
        end
        n_cmp++; if (ready_low !== 6)      begin n_mis++; $display("FAIL wait_ready_low: got %0d want 6", ready_low); end
        n_cmp++; if (done_cnt !== 1)       begin n_mis++; $display("FAIL wait_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (rd !== 32'h66554433)  begin n_mis++; $display("FAIL wait_misaligned_read: got %h want 66554433", rd); end
        n_cmp++; if (rd_err !== 1'b0)      begin n_mis++; $display("FAIL wait_err: got %b want 0", rd_err); end
    endtask

    task automatic test_out_of_range;
        int lat;
        dbg_addr[63:32] = 32'd350;
        dbg_addr[95:64] = 32'd348;
        req(1'b0, 32'd350, 1'b0, 4'hF, 32'hAABBCCDD, lat);
        n_cmp++; if (lat !== 3)    begin n_mis++; $display("FAIL oor_write_latency: got %0d want 3", lat); end
        n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL oor_write_err: got %b want 1", err); end
        n_cmp++; if (dbg_data[95:64] !== 32'h44332211) begin n_mis++; $display("FAIL oor_unchanged: got %h want 44332211", dbg_data[95:64]); end
        n_cmp++; if (dbg_data[63:32] !== 32'h00004433) begin n_mis++; $display("FAIL oor_dbg_mask: got %h want 00004433", dbg_data[63:32]); end
        req(1'b0, 32'd350, 1'b1, 4'h0, 32'h0, lat);
        n_cmp++; if (err !== 1'b1)         begin n_mis++; $display("FAIL oor_read_err: got %b want 1", err); end
        n_cmp++; if (data_out !== 32'h0)   begin n_mis++; $display("FAIL oor_read_data: got %h want 0", data_out); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0)  begin n_mis++; $display("FAIL oor_err_pulse: got %b want 0", err); end
        n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL oor_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_reset_abort;
        int lat;
        dbg_addr2 = 32'd16;
        start2 = 1'b1; rwn2 = 1'b0; address2 = 32'd16; byte_en2 = 4'hF; data_in2 = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start2 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (ready2 !== 1'b1)      begin n_mis++; $display("FAIL abort_ready: got %b want 1", ready2); end
        n_cmp++; if (done2 !== 1'b0)       begin n_mis++; $display("FAIL abort_done: got %b want 0", done2); end
        n_cmp++; if (data_out2 !== 32'h0)  begin n_mis++; $display("FAIL abort_data_out: got %h want 0", data_out2); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (dbg_data2 !== 32'h12345678) begin n_mis++; $display("FAIL abort_dbg: got %h want 12345678", dbg_data2); end
        reset = 1'b0;
        @(posedge clk); #1;
        req(1'b1, 32'd16, 1'b1, 4'h0, 32'h0, lat);
        n_cmp++; if (data_out2 !== 32'h12345678) begin n_mis++; $display("FAIL abort_readback: got %h want 12345678", data_out2); end
    endtask

    task automatic test_back_to_back;
        dbg_addr[31:0] = 32'd4;
        start = 1'b1; rwn = 1'b0; address = 32'd4; byte_en = 4'hF; data_in = 32'hCAFEF00D;
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b0)         begin n_mis++; $display("FAIL b2b_accept1: got ready %b want 0", ready); end
        n_cmp++; if (dbg_data[31:0] !== 32'h0) begin n_mis++; $display("FAIL b2b_dbg_old: got %h want 0", dbg_data[31:0]); end
        rwn = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b1)  begin n_mis++; $display("FAIL b2b_write_done: got %b want 1", done); end
        n_cmp++; if (ready !== 1'b1) begin n_mis++; $display("FAIL b2b_ready_gap: got %b want 1", ready); end
        n_cmp++; if (dbg_data[31:0] !== 32'hCAFEF00D) begin n_mis++; $display("FAIL b2b_dbg_new: got %h want cafef00d", dbg_data[31:0]); end
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b0) begin n_mis++; $display("FAIL b2b_accept2: got ready %b want 0", ready); end
        n_cmp++; if (done !== 1'b0)  begin n_mis++; $display("FAIL b2b_done_gap: got %b want 0", done); end
        start = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b1)              begin n_mis++; $display("FAIL b2b_read_done: got %b want 1", done); end
        n_cmp++; if (data_out !== 32'hCAFEF00D)  begin n_mis++; $display("FAIL b2b_read_data: got %h want cafef00d", data_out); end
        n_cmp++; if (err !== 1'b0)               begin n_mis++; $display("FAIL b2b_read_err: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_byte_en();
        test_wait_states();
        test_out_of_range();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
